seven_seg: RTL and testbench
============================

SEVEN_SEG -- requirements
Module: seven_seg

Interface
REQ-001 Parameter ACTIVE_LOW, default 0, segment polarity: 0 means a lit segment is driven 1; 1 means every output bit is inverted.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 bcd  input  4  digit code to display, unsigned 0-15.
REQ-005 blank  input  1  when 1, all segments are dark.
REQ-006 lamp_test  input  1  when 1, all segments are lit.
REQ-007 out  output  7  registered segment drive, bit order {g,f,e,d,c,b,a}, with bit 0 = a.
REQ-008 valid  output  1  registered; 1 from the first clock edge after reset release onward.

Function
REQ-009 out SHALL be a register updated every rising clk edge from the inputs sampled at that edge: one cycle of latency, no enable and no handshake.
REQ-010 Selection priority SHALL be lamp_test, then blank, then bcd decode.
REQ-011 The active-high decode for bcd 0-9 SHALL be: 0=0x3F, 1=0x06, 2=0x5B, 3=0x4F, 4=0x66, 5=0x6D, 6=0x7D, 7=0x07, 8=0x7F, 9=0x6F.
REQ-012 bcd 10-15 SHALL decode per REQ-021/REQ-022; no input value SHALL produce X or hold the previous value.
REQ-013 lamp_test=1 SHALL yield active-high 0x7F.
REQ-014 blank=1 with lamp_test=0 SHALL yield active-high 0x00.
REQ-015 With ACTIVE_LOW=1, the registered value SHALL be the bitwise inverse of the active-high code, including the reset value.
REQ-016 A change on bcd, blank or lamp_test SHALL appear on out exactly one edge later, with no intermediate code.
REQ-017 valid SHALL rise at the first rising edge after rst_n deasserts and stay 1 until the next reset.

Reset
REQ-018 Asserting rst_n=0 SHALL immediately, independent of clk, force out to the dark code and valid to 0.
      - Dark code: 0x00 when ACTIVE_LOW=0; 0x7F when ACTIVE_LOW=1.
REQ-019 While rst_n=0, outputs SHALL hold their reset values regardless of clock or inputs.
REQ-020 Reset asserted mid-operation SHALL override any pending update; the first post-reset edge SHALL load the decode of the inputs current at that edge.

Configuration
REQ-021 With macro SEVEN_SEG_HEX_EN defined, bcd 10-15 SHALL display hex glyphs with active-high codes A=0x77, b=0x7C, C=0x39, d=0x5E, E=0x79, F=0x71.
REQ-022 Without SEVEN_SEG_HEX_EN, bcd 10-15 SHALL display a dash (segment g only, active-high 0x40).

Verification
REQ-023 Reset: assert rst_n=0 between clock edges -> out=0x00 and valid=0 immediately, without waiting for a clock edge.
REQ-024 Decode sweep: ACTIVE_LOW=0, bcd stepped 0..15 one per 10 ns clock cycle -> out, one cycle later, matches the REQ-011 table for 0-9.
      - 10-15 with SEVEN_SEG_HEX_EN: 0x77, 0x7C, 0x39, 0x5E, 0x79, 0x71.
      - 10-15 without it: 0x40 each.
REQ-025 Priority: bcd=8 with blank=1 -> 0x00; then lamp_test=1 with blank=1 -> 0x7F; then both low -> 0x7F from the bcd=8 decode.
REQ-026 Polarity: ACTIVE_LOW=1, bcd=1 -> out=0x79 one cycle later; reset value 0x7F.
REQ-027 Latency: bcd changes 3->5 at edge N -> out=0x4F until edge N+1, then 0x6D.

Source files
------------

// File: rtl/seven_seg_if.sv
// seven_seg_if -- display request/response bundle for seven_seg.
//   bcd       : digit code 0-15 (driven by master)
//   blank     : force all segments dark (driven by master)
//   lamp_test : force all segments lit (driven by master)
//   out       : registered segment drive {g,f,e,d,c,b,a} (driven by slave)
//   valid     : high from the first edge after reset release (driven by slave)
interface seven_seg_if;
  logic [3:0] bcd;
  logic       blank;
  logic       lamp_test;
  logic [6:0] out;
  logic       valid;

  modport master (output bcd, output blank, output lamp_test,
                  input  out, input  valid);
  modport slave  (input  bcd, input  blank, input  lamp_test,
                  output out, output valid);
endinterface

// File: rtl/seven_seg.sv
// seven_seg -- registered 7-segment decoder with blank and lamp test.
//   Parameter ACTIVE_LOW : 0 = lit segment drives 1, 1 = all outputs inverted.
//   Macro SEVEN_SEG_HEX_EN : when defined, codes 10-15 show hex glyphs
//                            A b C d E F; otherwise they show a dash.
// Ports:
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset (out -> dark, valid -> 0)
//   bus   : seven_seg_if.slave (bcd/blank/lamp_test in, out/valid out)
// Timing: one cycle from inputs to out, no enable, no handshake.
module seven_seg #(
  parameter bit ACTIVE_LOW = 1'b0
) (
  input logic         clk,
  input logic         rst_n,
  seven_seg_if.slave  bus
);

  // XOR mask applied to every active-high code; also the dark code.
  localparam logic [6:0] POL = ACTIVE_LOW ? 7'h7F : 7'h00;

  // Active-high segment patterns, bit order {g,f,e,d,c,b,a}.
  function automatic logic [6:0] decode(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'h3F;
      4'd1:    s = 7'h06;
      4'd2:    s = 7'h5B;
      4'd3:    s = 7'h4F;
      4'd4:    s = 7'h66;
      4'd5:    s = 7'h6D;
      4'd6:    s = 7'h7D;
      4'd7:    s = 7'h07;
      4'd8:    s = 7'h7F;
      4'd9:    s = 7'h6F;
`ifdef SEVEN_SEG_HEX_EN
      4'd10:   s = 7'h77;
      4'd11:   s = 7'h7C;
      4'd12:   s = 7'h39;
      4'd13:   s = 7'h5E;
      4'd14:   s = 7'h79;
      4'd15:   s = 7'h71;
`endif
      // Non-decimal codes without hex support show segment g only.
      default: s = 7'h40;
    endcase
    return s;
  endfunction

  logic [6:0] seg_nxt;
  logic [6:0] out_q;
  logic       vld_q;

  // Lamp test beats blank, blank beats the digit.
  always_comb begin
    seg_nxt = decode(bus.bcd);
    if (bus.lamp_test)  seg_nxt = 7'h7F;
    else if (bus.blank) seg_nxt = 7'h00;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q <= POL;
      vld_q <= 1'b0;
    end else begin
      out_q <= seg_nxt ^ POL;
      vld_q <= 1'b1;
    end
  end

  assign bus.out   = out_q;
  assign bus.valid = vld_q;

endmodule

// File: tb/tb_seven_seg.sv
// tb_seven_seg -- directed check of seven_seg in both polarities.
// Two instances share clock and reset: ACTIVE_LOW=0 (u_hi) and
// ACTIVE_LOW=1 (u_lo). Expected codes are hand-written constants.
module tb_seven_seg;

  logic clk;
  logic rst_n;
  int   vectors;
  int   miscompares;

  seven_seg_if if_hi ();
  seven_seg_if if_lo ();

  seven_seg #(.ACTIVE_LOW(1'b0)) u_hi (.clk(clk), .rst_n(rst_n), .bus(if_hi.slave));
  seven_seg #(.ACTIVE_LOW(1'b1)) u_lo (.clk(clk), .rst_n(rst_n), .bus(if_lo.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Active-high expectations, 0-15.
  logic [6:0] exp_tab [16];
  initial begin
    exp_tab[0] = 7'h3F; exp_tab[1] = 7'h06; exp_tab[2] = 7'h5B; exp_tab[3] = 7'h4F;
    exp_tab[4] = 7'h66; exp_tab[5] = 7'h6D; exp_tab[6] = 7'h7D; exp_tab[7] = 7'h07;
    exp_tab[8] = 7'h7F; exp_tab[9] = 7'h6F;
`ifdef SEVEN_SEG_HEX_EN
    exp_tab[10] = 7'h77; exp_tab[11] = 7'h7C; exp_tab[12] = 7'h39;
    exp_tab[13] = 7'h5E; exp_tab[14] = 7'h79; exp_tab[15] = 7'h71;
`else
    for (int i = 10; i < 16; i++) exp_tab[i] = 7'h40;
`endif
  end

  task automatic chk(input string tag, input logic [6:0] got, input logic [6:0] want);
    vectors++;
    assert (got === want) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, got, want);
    end
  endtask

  // Drive both instances identically.
  task automatic drive(input logic [3:0] d, input logic bl, input logic lt);
    if_hi.bcd = d; if_hi.blank = bl; if_hi.lamp_test = lt;
    if_lo.bcd = d; if_lo.blank = bl; if_lo.lamp_test = lt;
  endtask

  // Drive at the falling edge, check 1 ns after the following rising edge.
  task automatic step(input logic [3:0] d, input logic bl, input logic lt,
                      input logic [6:0] want, input string tag);
    @(negedge clk);
    drive(d, bl, lt);
    @(posedge clk);
    #1;
    chk({tag, "_hi"}, if_hi.out, want);
    chk({tag, "_lo"}, if_lo.out, ~want);
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    rst_n = 1'b1;
    drive(4'd8, 1'b0, 1'b0);
    #2;

    // Reset asserted between edges takes effect with no clock edge.
    rst_n = 1'b0;
    #1;
    chk("rst_async_out_hi", if_hi.out, 7'h00);
    chk("rst_async_out_lo", if_lo.out, 7'h7F);
    chk("rst_async_valid", {6'd0, if_hi.valid}, 7'h00);

    // Held through clocks and active inputs.
    drive(4'd8, 1'b0, 1'b1);
    repeat (3) @(posedge clk);
    #1;
    chk("rst_hold_out_hi", if_hi.out, 7'h00);
    chk("rst_hold_out_lo", if_lo.out, 7'h7F);
    chk("rst_hold_valid", {6'd0, if_lo.valid}, 7'h00);

    // Release at a falling edge; valid and the decode arrive on the next rise.
    @(negedge clk);
    drive(4'd0, 1'b0, 1'b0);
    rst_n = 1'b1;
    #1;
    chk("pre_edge_valid", {6'd0, if_hi.valid}, 7'h00);
    @(posedge clk);
    #1;
    chk("first_edge_valid", {6'd0, if_hi.valid}, 7'h01);
    chk("first_edge_out", if_hi.out, 7'h3F);

    // Full sweep of codes 0-15.
    for (int i = 0; i < 16; i++)
      step(4'(i), 1'b0, 1'b0, exp_tab[i], $sformatf("sweep%0d", i));

    // Priority: blank over digit, lamp test over blank, then digit again.
    step(4'd8, 1'b1, 1'b0, 7'h00, "prio_blank");
    step(4'd8, 1'b1, 1'b1, 7'h7F, "prio_lamp");
    step(4'd8, 1'b0, 1'b0, 7'h7F, "prio_digit");
    step(4'd3, 1'b0, 1'b1, 7'h7F, "lamp_over_digit");
    step(4'd1, 1'b0, 1'b0, 7'h06, "polarity_one");  // u_lo expects 0x79

    // Latency: 3 then 5; old code holds until the capturing edge.
    step(4'd3, 1'b0, 1'b0, 7'h4F, "lat_three");
    @(negedge clk);
    drive(4'd5, 1'b0, 1'b0);
    #1;
    chk("lat_hold", if_hi.out, 7'h4F);
    @(posedge clk);
    #1;
    chk("lat_update", if_hi.out, 7'h6D);
    chk("lat_valid", {6'd0, if_hi.valid}, 7'h01);

    // Mid-operation reset overrides the pending update.
    @(negedge clk);
    drive(4'd2, 1'b0, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_out_hi", if_hi.out, 7'h00);
    chk("mid_rst_out_lo", if_lo.out, 7'h7F);
    chk("mid_rst_valid", {6'd0, if_hi.valid}, 7'h00);
    @(posedge clk);
    #1;
    chk("mid_rst_edge_hi", if_hi.out, 7'h00);
    @(negedge clk);
    rst_n = 1'b1;
    drive(4'd7, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    chk("post_rst_load_hi", if_hi.out, 7'h07);
    chk("post_rst_load_lo", if_lo.out, 7'h78);
    chk("post_rst_valid", {6'd0, if_lo.valid}, 7'h01);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
